// File: rtl/disp_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
//   scan_state_t : scan FSM state encoding
//   NUM_DIGITS   : digits on the display
//   AN_OFF       : anode pattern with every digit dark (anodes are active-low)
//   an_onehot_low: anode pattern lighting exactly one digit
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [3:0]  AN_OFF     = 4'hF;

    function automatic logic [3:0] an_onehot_low(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_next_digit_sel.sv
// Combinational digit picker for the scan controller.
// Ports:
//   sel      in  2  currently selected digit
//   digit_en in  4  per-digit enable mask
//   next_sel out 2  first enabled digit after sel (sel+1..sel+3, wrapping),
//                   falling back to sel itself
//   low_sel  out 2  lowest enabled digit (0 when the mask is empty)
module next_digit_sel
    import disp_pkg::*;
(
    input  logic [1:0] sel,
    input  logic [3:0] digit_en,
    output logic [1:0] next_sel,
    output logic [1:0] low_sel
);

    logic [1:0] cand;

    always_comb begin
        cand     = sel;
        next_sel = sel;
        // Walk from the farthest offset down so the nearest enabled digit wins.
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            cand = sel + 2'(k);
            if (digit_en[cand]) begin
                next_sel = cand;
            end
        end
    end

    always_comb begin
        low_sel = 2'd0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (digit_en[i]) begin
                low_sel = 2'(i);
            end
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Drives the digit mux select, active-low anodes and active-low decimal point.
// Each digit period is TICK_DIV cycles: BLANK_CYC dark cycles while the mux and
// decoder settle, then the selected digit is lit for the rest of the period.
// Ports:
//   clk      in  1  system clock
//   reset    in  1  asynchronous active-high reset
//   en       in  1  scan enable; 0 keeps the display dark
//   digit_en in  4  per-digit enable mask
//   dp_in    in  4  decimal point request per digit, active-high
//   sel      out 2  digit mux select
//   an       out 4  anode enables, active-low, at most one low
//   dp       out 1  decimal point, active-low
// All outputs are registered.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100_000,
    parameter int unsigned BLANK_CYC = 1_000,
    parameter int unsigned CNT_W     = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] digit_en,
    input  logic [3:0] dp_in,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic       dp
);

    if (BLANK_CYC < 1 || BLANK_CYC >= TICK_DIV) begin : gen_param_check
        $error("disp_scan_ctrl: need 1 <= BLANK_CYC < TICK_DIV");
    end

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       an_q, an_d;
    logic             dp_q, dp_d;

    logic [1:0]       next_sel;
    logic [1:0]       low_sel;

    next_digit_sel u_next_digit_sel (
        .sel      (sel_q),
        .digit_en (digit_en),
        .next_sel (next_sel),
        .low_sel  (low_sel)
    );

    // State register (outputs registered alongside so they track the state).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            an_q    <= AN_OFF;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        if (!en || digit_en == 4'h0) begin
            // Going dark from any state; sel is kept.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    sel_d   = low_sel;
                end
                BLANK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt_q == TICK_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        sel_d   = next_sel;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output logic, computed from the next state so the registered outputs
    // line up with the registered state.
    always_comb begin
        an_d = AN_OFF;
        dp_d = 1'b1;
        if (state_d == SHOW) begin
            dp_d = ~dp_in[sel_d];
            // A digit disabled mid-period goes dark immediately.
            if (digit_en[sel_d]) begin
                an_d = an_onehot_low(sel_d);
            end
        end
    end

    assign sel = sel_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule
